text_writer: RTL and testbench

- Byte-stream front end that drives the video memory write port (write, xtextwrite, ytextwrite, value).
- Accepts one byte per valid/ready handshake, typically from the UART/host link.
- Keeps a cursor and a current attribute register. Printable bytes become cell writes; control codes move the cursor, set the attribute or clear the screen.
- Sits between the host interface and the video memory write port.

---
 rtl/text_writer_if.sv | 31 +++
 rtl/text_writer.sv | 186 ++++++++++++++++++
 tb/tb_text_writer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/text_writer_if.sv
// Byte-input handshake and video-memory write port of text_writer.
// The slave modport is the writer's own view; master is the host/memory side.
interface text_writer_if #(
  parameter int XW     = 7,
  parameter int YW     = 5,
  parameter int CHAR_W = 8,
  parameter int ATTR_W = 16
);
  logic [7:0]               in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     write;
  logic [XW-1:0]            xtextwrite;
  logic [YW-1:0]            ytextwrite;
  logic [CHAR_W+ATTR_W-1:0] value;
  logic [XW-1:0]            cursor_x;
  logic [YW-1:0]            cursor_y;
  logic                     busy;

  modport slave (
    input  in_data, in_valid,
    output in_ready, write, xtextwrite, ytextwrite, value,
           cursor_x, cursor_y, busy
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, write, xtextwrite, ytextwrite, value,
           cursor_x, cursor_y, busy
  );
endinterface

// File: rtl/text_writer.sv
// Byte-stream text writer: turns printable bytes into cell writes at a
// cursor, interprets CR/LF/BS/FF and ESC (attribute) / US (cursor) sequences,
// and sweeps the whole screen with blanks on FF.
module text_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 25,
  parameter int          XW         = 7,
  parameter int          YW         = 5,
  parameter int          CHAR_W     = 8,
  parameter int          ATTR_W     = 16,
  parameter logic [15:0] ATTR_RESET = 16'h0070
) (
  input  logic          clk,
  input  logic          reset,
  text_writer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, ESC_HI, ESC_LO, US_ROW, US_COL, CLEAR
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  state_t                   state_q, state_d;
  logic [XW-1:0]            cx_q, cx_d;
  logic [YW-1:0]            cy_q, cy_d;
  logic [ATTR_W-1:0]        attr_q, attr_d;
  logic [7:0]               hi_q, hi_d;
  logic [7:0]               row_q, row_d;
  logic [XW-1:0]            sx_q, sx_d;
  logic [YW-1:0]            sy_q, sy_d;
  logic                     wr_q, wr_d;
  logic [XW-1:0]            wx_q, wx_d;
  logic [YW-1:0]            wy_q, wy_d;
  logic [CHAR_W+ATTR_W-1:0] wval_q, wval_d;

  logic       accept;
  logic [15:0] attr_word;

  // No bytes are taken while the clear sweep owns the write port.
  assign accept    = bus.in_valid && (state_q != CLEAR);
  assign attr_word = {hi_q, bus.in_data};

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    attr_d  = attr_q;
    hi_d    = hi_q;
    row_d   = row_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    wr_d    = 1'b0;
    wx_d    = wx_q;
    wy_d    = wy_q;
    wval_d  = wval_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_data >= 8'h20) begin
            wr_d   = 1'b1;
            wx_d   = cx_q;
            wy_d   = cy_q;
            wval_d = {attr_q, CHAR_W'(bus.in_data)};
            if (cx_q == X_LAST) begin
              cx_d = '0;
              cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
            end else begin
              cx_d = cx_q + 1'b1;
            end
          end else begin
            case (bus.in_data)
              8'h0D: cx_d = '0;
              8'h0A: cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
              8'h08: begin
                if (cx_q != '0) begin
                  cx_d = cx_q - 1'b1;
                end else if (cy_q != '0) begin
                  cx_d = X_LAST;
                  cy_d = cy_q - 1'b1;
                end
              end
              8'h0C: begin
                state_d = CLEAR;
                sx_d    = '0;
                sy_d    = '0;
              end
              8'h1B:   state_d = ESC_HI;
              8'h1F:   state_d = US_ROW;
              default: ;
            endcase
          end
        end
      end
      ESC_HI: begin
        if (accept) begin
          hi_d    = bus.in_data;
          state_d = ESC_LO;
        end
      end
      ESC_LO: begin
        if (accept) begin
          attr_d  = attr_word[ATTR_W-1:0];
          state_d = IDLE;
        end
      end
      US_ROW: begin
        if (accept) begin
          row_d   = bus.in_data;
          state_d = US_COL;
        end
      end
      US_COL: begin
        if (accept) begin
          cx_d    = (int'(bus.in_data) >= COLS) ? X_LAST : XW'(bus.in_data);
          cy_d    = (int'(row_q) >= ROWS) ? Y_LAST : YW'(row_q);
          state_d = IDLE;
        end
      end
      CLEAR: begin
        wr_d   = 1'b1;
        wx_d   = sx_q;
        wy_d   = sy_q;
        wval_d = {attr_q, CHAR_W'(8'h20)};
        if (sx_q == X_LAST) begin
          sx_d = '0;
          if (sy_q == Y_LAST) begin
            sy_d    = '0;
            cx_d    = '0;
            cy_d    = '0;
            state_d = IDLE;
          end else begin
            sy_d = sy_q + 1'b1;
          end
        end else begin
          sx_d = sx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any sweep or partial sequence at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      attr_q  <= ATTR_RESET[ATTR_W-1:0];
      hi_q    <= '0;
      row_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      wr_q    <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      wval_q  <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      attr_q  <= attr_d;
      hi_q    <= hi_d;
      row_q   <= row_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      wr_q    <= wr_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wval_q  <= wval_d;
    end
  end

  assign bus.in_ready   = (state_q != CLEAR);
  assign bus.busy       = (state_q == CLEAR);
  assign bus.write      = wr_q;
  assign bus.xtextwrite = wx_q;
  assign bus.ytextwrite = wy_q;
  assign bus.value      = wval_q;
  assign bus.cursor_x   = cx_q;
  assign bus.cursor_y   = cy_q;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: an 80x25 instance driven from a vector
// table, and a 4x3 instance for the clear sweep and reset-during-clear.
module tb_text_writer;

  logic clk;
  logic rst80;
  logic rst4;

  int n_checks = 0;
  int n_err    = 0;

  text_writer_if #(.XW(7), .YW(5), .CHAR_W(8), .ATTR_W(16)) if80 ();
  text_writer_if #(.XW(7), .YW(5), .CHAR_W(8), .ATTR_W(16)) if4 ();

  text_writer #(.COLS(80), .ROWS(25)) dut80 (.clk(clk), .reset(rst80), .bus(if80));
  text_writer #(.COLS(4),  .ROWS(3))  dut4  (.clk(clk), .reset(rst4),  .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    logic        wr;
    int          wx;
    int          wy;
    logic [23:0] val;
    int          cx;
    int          cy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] din, logic wr, int wx, int wy,
                              logic [23:0] val, int cx, int cy);
    vec_t v;
    v.din = din; v.wr = wr; v.wx = wx; v.wy = wy;
    v.val = val; v.cx = cx; v.cy = cy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send80(input logic [7:0] b);
    if80.in_data  = b;
    if80.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if80.in_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b);
    if4.in_data  = b;
    if4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if4.in_valid = 1'b0;
  endtask

  initial begin
    int nw;
    if80.in_data = 8'h00; if80.in_valid = 1'b0;
    if4.in_data  = 8'h00; if4.in_valid  = 1'b0;
    rst80 = 1'b1;
    rst4  = 1'b1;
    #1;
    check("rst_write",  32'(if80.write), 32'd0);
    check("rst_xw",     32'(if80.xtextwrite), 32'd0);
    check("rst_yw",     32'(if80.ytextwrite), 32'd0);
    check("rst_value",  32'(if80.value), 32'd0);
    check("rst_cx",     32'(if80.cursor_x), 32'd0);
    check("rst_cy",     32'(if80.cursor_y), 32'd0);
    check("rst_busy",   32'(if80.busy), 32'd0);
    check("rst_ready",  32'(if80.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst80 = 1'b0;
    rst4  = 1'b0;

    // ---------------- table-driven 80x25 sequence ----------------
    vecs.push_back(mk(8'h41, 1, 0, 0, 24'h007041, 1, 0));
    vecs.push_back(mk(8'h1F, 0, 0, 0, 24'h0, 1, 0));
    vecs.push_back(mk(8'h02, 0, 0, 0, 24'h0, 1, 0));
    vecs.push_back(mk(8'h4F, 0, 0, 0, 24'h0, 79, 2));
    vecs.push_back(mk(8'h5A, 1, 79, 2, 24'h00705A, 0, 3));
    vecs.push_back(mk(8'h1F, 0, 0, 0, 24'h0, 0, 3));
    vecs.push_back(mk(8'h18, 0, 0, 0, 24'h0, 0, 3));
    vecs.push_back(mk(8'h4F, 0, 0, 0, 24'h0, 79, 24));
    vecs.push_back(mk(8'h51, 1, 79, 24, 24'h007051, 0, 0));
    vecs.push_back(mk(8'h1B, 0, 0, 0, 24'h0, 0, 0));
    vecs.push_back(mk(8'h12, 0, 0, 0, 24'h0, 0, 0));
    vecs.push_back(mk(8'h34, 0, 0, 0, 24'h0, 0, 0));
    vecs.push_back(mk(8'h42, 1, 0, 0, 24'h123442, 1, 0));
    vecs.push_back(mk(8'h1F, 0, 0, 0, 24'h0, 1, 0));
    vecs.push_back(mk(8'h63, 0, 0, 0, 24'h0, 1, 0));
    vecs.push_back(mk(8'hC8, 0, 0, 0, 24'h0, 79, 24));
    vecs.push_back(mk(8'h1F, 0, 0, 0, 24'h0, 79, 24));
    vecs.push_back(mk(8'h01, 0, 0, 0, 24'h0, 79, 24));
    vecs.push_back(mk(8'h00, 0, 0, 0, 24'h0, 0, 1));
    vecs.push_back(mk(8'h08, 0, 0, 0, 24'h0, 79, 0));
    vecs.push_back(mk(8'h1F, 0, 0, 0, 24'h0, 79, 0));
    vecs.push_back(mk(8'h00, 0, 0, 0, 24'h0, 79, 0));
    vecs.push_back(mk(8'h00, 0, 0, 0, 24'h0, 0, 0));
    vecs.push_back(mk(8'h08, 0, 0, 0, 24'h0, 0, 0));
    vecs.push_back(mk(8'h1F, 0, 0, 0, 24'h0, 0, 0));
    vecs.push_back(mk(8'h03, 0, 0, 0, 24'h0, 0, 0));
    vecs.push_back(mk(8'h05, 0, 0, 0, 24'h0, 5, 3));
    vecs.push_back(mk(8'h0D, 0, 0, 0, 24'h0, 0, 3));
    vecs.push_back(mk(8'h1F, 0, 0, 0, 24'h0, 0, 3));
    vecs.push_back(mk(8'h18, 0, 0, 0, 24'h0, 0, 3));
    vecs.push_back(mk(8'h05, 0, 0, 0, 24'h0, 5, 24));
    vecs.push_back(mk(8'h0A, 0, 0, 0, 24'h0, 5, 0));
    vecs.push_back(mk(8'h07, 0, 0, 0, 24'h0, 5, 0));
    vecs.push_back(mk(8'h1B, 0, 0, 0, 24'h0, 5, 0));
    vecs.push_back(mk(8'h0D, 0, 0, 0, 24'h0, 5, 0));
    vecs.push_back(mk(8'h0A, 0, 0, 0, 24'h0, 5, 0));
    vecs.push_back(mk(8'h43, 1, 5, 0, 24'h0D0A43, 6, 0));
    vecs.push_back(mk(8'h1F, 0, 0, 0, 24'h0, 6, 0));
    vecs.push_back(mk(8'h0D, 0, 0, 0, 24'h0, 6, 0));
    vecs.push_back(mk(8'h0D, 0, 0, 0, 24'h0, 13, 13));
    vecs.push_back(mk(8'hFF, 1, 13, 13, 24'h0D0AFF, 14, 13));
    vecs.push_back(mk(8'h13, 0, 0, 0, 24'h0, 14, 13));
    vecs.push_back(mk(8'h0A, 0, 0, 0, 24'h0, 14, 14));

    for (int i = 0; i < vecs.size(); i++) begin
      send80(vecs[i].din);
      $display("vec %0d: byte %h write=%0b at (%0d,%0d) value=%h cursor=(%0d,%0d)",
               i, vecs[i].din, if80.write, if80.xtextwrite, if80.ytextwrite,
               if80.value, if80.cursor_x, if80.cursor_y);
      check($sformatf("v%0d_write", i), 32'(if80.write), 32'(vecs[i].wr));
      if (vecs[i].wr) begin
        check($sformatf("v%0d_xw", i),    32'(if80.xtextwrite), 32'(vecs[i].wx));
        check($sformatf("v%0d_yw", i),    32'(if80.ytextwrite), 32'(vecs[i].wy));
        check($sformatf("v%0d_value", i), 32'(if80.value),      32'(vecs[i].val));
      end
      check($sformatf("v%0d_cx", i), 32'(if80.cursor_x), 32'(vecs[i].cx));
      check($sformatf("v%0d_cy", i), 32'(if80.cursor_y), 32'(vecs[i].cy));
    end

    // Write strobe lasts one cycle.
    send80(8'h61);
    check("pulse_hi", 32'(if80.write), 32'd1);
    @(posedge clk); #1;
    check("pulse_lo", 32'(if80.write), 32'd0);
    check("pulse_cx", 32'(if80.cursor_x), 32'd15);
    $display("pulse: write=%0b cursor=(%0d,%0d)", if80.write, if80.cursor_x, if80.cursor_y);

    // Reset mid-escape discards the partial sequence and restores attr.
    send80(8'h1B);
    send80(8'h12);
    rst80 = 1'b1;
    #1;
    check("escrst_cx", 32'(if80.cursor_x), 32'd0);
    check("escrst_cy", 32'(if80.cursor_y), 32'd0);
    @(posedge clk); #1;
    rst80 = 1'b0;
    send80(8'h42);
    $display("esc reset: write=%0b value=%h", if80.write, if80.value);
    check("escrst_write", 32'(if80.write), 32'd1);
    check("escrst_value", 32'(if80.value), 32'h007042);

    // ---------------- 4x3 clear sweep ----------------
    send4(8'h1B);
    send4(8'hAB);
    send4(8'hCD);
    send4(8'h61);
    check("c4_pre_value", 32'(if4.value), 32'hABCD61);
    check("c4_pre_cx",    32'(if4.cursor_x), 32'd1);
    if4.in_data  = 8'h0C;
    if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_data = 8'h41;   // held across the sweep
    check("c4_start_busy",  32'(if4.busy), 32'd1);
    check("c4_start_ready", 32'(if4.in_ready), 32'd0);
    check("c4_start_write", 32'(if4.write), 32'd0);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      $display("clear cyc %0d: write=%0b (%0d,%0d) value=%h busy=%0b ready=%0b",
               k, if4.write, if4.xtextwrite, if4.ytextwrite, if4.value,
               if4.busy, if4.in_ready);
      check($sformatf("c4_k%0d_write", k), 32'(if4.write), 32'd1);
      if (k <= 12) begin
        check($sformatf("c4_k%0d_x", k), 32'(if4.xtextwrite), 32'((k - 1) % 4));
        check($sformatf("c4_k%0d_y", k), 32'(if4.ytextwrite), 32'((k - 1) / 4));
        check($sformatf("c4_k%0d_value", k), 32'(if4.value), 32'hABCD20);
        if (k <= 11) begin
          check($sformatf("c4_k%0d_ready", k), 32'(if4.in_ready), 32'd0);
          check($sformatf("c4_k%0d_busy", k),  32'(if4.busy), 32'd1);
        end
        if (k == 12) begin
          check("c4_end_cx", 32'(if4.cursor_x), 32'd0);
          check("c4_end_cy", 32'(if4.cursor_y), 32'd0);
        end
      end else begin
        if4.in_valid = 1'b0;
        check("c4_held_x",     32'(if4.xtextwrite), 32'd0);
        check("c4_held_y",     32'(if4.ytextwrite), 32'd0);
        check("c4_held_value", 32'(if4.value), 32'hABCD41);
        check("c4_held_cx",    32'(if4.cursor_x), 32'd1);
      end
    end
    @(posedge clk); #1;
    check("c4_after_write", 32'(if4.write), 32'd0);
    check("c4_after_busy",  32'(if4.busy), 32'd0);
    check("c4_after_ready", 32'(if4.in_ready), 32'd1);

    // ---------------- reset during the clear sweep ----------------
    send4(8'h1F);
    send4(8'h01);
    send4(8'h02);
    check("r4_cx", 32'(if4.cursor_x), 32'd2);
    check("r4_cy", 32'(if4.cursor_y), 32'd1);
    send4(8'h0C);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
    end
    check("r4_k5_write", 32'(if4.write), 32'd1);
    check("r4_k5_y",     32'(if4.ytextwrite), 32'd1);
    rst4 = 1'b1;
    #1;
    $display("clear reset: write=%0b cursor=(%0d,%0d) ready=%0b busy=%0b",
             if4.write, if4.cursor_x, if4.cursor_y, if4.in_ready, if4.busy);
    check("r4_write", 32'(if4.write), 32'd0);
    check("r4_rcx",   32'(if4.cursor_x), 32'd0);
    check("r4_rcy",   32'(if4.cursor_y), 32'd0);
    check("r4_ready", 32'(if4.in_ready), 32'd1);
    check("r4_busy",  32'(if4.busy), 32'd0);
    @(posedge clk); #1;
    rst4 = 1'b0;
    nw = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (if4.write) nw++;
    end
    $display("after clear reset: %0d writes in 20 cycles", nw);
    check("r4_quiet", 32'(nw), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
